// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP: controller state encoding, fixed
// instruction codes and the instruction decoder used by the core.
`timescale 1ns/1ps
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [7:0] INSTR_EXTEST         = 8'h00;
    localparam logic [7:0] INSTR_IDCODE         = 8'h01;
    localparam logic [7:0] INSTR_SAMPLE_PRELOAD = 8'h02;
    localparam logic [7:0] USER_BASE            = 8'h04;

    typedef enum logic [2:0] {
        I_BYPASS,
        I_EXTEST,
        I_IDCODE,
        I_SAMPLE,
        I_USER
    } instr_kind_t;

    typedef struct packed {
        instr_kind_t kind;
        logic [1:0]  user_idx;
    } instr_dec_t;

    // All-ones always wins so that it stays BYPASS even where it overlaps a user code.
    function automatic instr_dec_t decode_instr(input logic [7:0] code,
                                                input logic       all_ones,
                                                input logic [7:0] num_ch);
        instr_dec_t dec;
        dec.kind     = I_BYPASS;
        dec.user_idx = 2'd0;
        if (all_ones)                               dec.kind = I_BYPASS;
        else if (code == INSTR_EXTEST)              dec.kind = I_EXTEST;
        else if (code == INSTR_IDCODE)              dec.kind = I_IDCODE;
        else if (code == INSTR_SAMPLE_PRELOAD)      dec.kind = I_SAMPLE;
        else if (code >= USER_BASE && code < USER_BASE + num_ch) begin
            dec.kind     = I_USER;
            dec.user_idx = 2'(code - USER_BASE);
        end
        return dec;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine stepped by TMS on rising TCK.
`timescale 1ns/1ps
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t state_q, state_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) state_q <= TEST_LOGIC_RESET;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_comb state = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: instruction register, bypass/IDCODE/user data registers and
// boundary-scan control gating around the shared TAP controller.
`timescale 1ns/1ps
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH = 4,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CH_WIDTH = 8,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic                         tck,
    input  logic                         trst,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    output tap_state_t                   tap_state,
    output logic [IR_WIDTH-1:0]          ir_value,
    output logic                         bsr_tdi,
    output logic                         bsr_shift,
    output logic                         bsr_capture,
    output logic                         bsr_update,
    output logic                         bsr_mode,
    input  logic                         bsr_tdo,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_cap_data,
    output logic [NUM_CH-1:0]            ch_cap_strobe,
    output logic [NUM_CH*CH_WIDTH-1:0]   ch_upd_data,
    output logic [NUM_CH-1:0]            ch_upd_valid
);

    tap_state_t state;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    assign tap_state = state;

    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d, ir_cur;
    instr_dec_t          dec;

    // Override in TEST_LOGIC_RESET so IDCODE is active the moment the state is entered.
    assign ir_cur   = (state == TEST_LOGIC_RESET) ? IR_WIDTH'(INSTR_IDCODE) : ir_q;
    assign ir_value = ir_cur;
    assign dec      = decode_instr(8'(ir_cur), &ir_cur, 8'(NUM_CH));

    always_comb begin
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        case (state)
            TEST_LOGIC_RESET: ir_d    = IR_WIDTH'(INSTR_IDCODE);
            CAPTURE_IR:       ir_sr_d = IR_WIDTH'(2'b01);
            SHIFT_IR:         ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            UPDATE_IR:        ir_d    = ir_sr_q;
            default: ;
        endcase
    end

    logic        bypass_q, bypass_d;
    logic [31:0] id_q, id_d;

    always_comb begin
        bypass_d = bypass_q;
        id_d     = id_q;
        if (state == CAPTURE_DR) begin
            if (dec.kind == I_BYPASS) bypass_d = 1'b0;
            if (dec.kind == I_IDCODE) id_d     = IDCODE;
        end else if (state == SHIFT_DR) begin
            if (dec.kind == I_BYPASS) bypass_d = tdi;
            if (dec.kind == I_IDCODE) id_d     = {tdi, id_q[31:1]};
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr_q  <= '0;
            ir_q     <= IR_WIDTH'(INSTR_IDCODE);
            bypass_q <= 1'b0;
            id_q     <= '0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            ir_q     <= ir_d;
            bypass_q <= bypass_d;
            id_q     <= id_d;
        end
    end

    logic [NUM_CH-1:0] user_sel;
    logic [NUM_CH-1:0] ch_sr_lsb;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CH_WIDTH-1:0] sr_q, sr_d, upd_q, upd_d;
        logic                valid_q, valid_d;

        assign user_sel[k] = (dec.kind == I_USER) && (dec.user_idx == 2'(k));

        always_comb begin
            sr_d    = sr_q;
            upd_d   = upd_q;
            valid_d = 1'b0;
            if (user_sel[k]) begin
                case (state)
                    CAPTURE_DR: sr_d = ch_cap_data[k*CH_WIDTH +: CH_WIDTH];
                    SHIFT_DR:   sr_d = {tdi, sr_q[CH_WIDTH-1:1]};
                    UPDATE_DR: begin
                        upd_d   = sr_q;
                        valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // NOTE: every data register, including the update holding register, is reset explicitly.
        always_ff @(posedge tck or posedge trst) begin
            if (trst) begin
                sr_q    <= '0;
                upd_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                sr_q    <= sr_d;
                upd_q   <= upd_d;
                valid_q <= valid_d;
            end
        end

        assign ch_cap_strobe[k]                       = user_sel[k] && (state == CAPTURE_DR);
        assign ch_upd_data[k*CH_WIDTH +: CH_WIDTH]    = upd_q;
        assign ch_upd_valid[k]                        = valid_q;
        assign ch_sr_lsb[k]                           = sr_q[0];
    end

    logic bsr_sel;
    logic dr_tdo;

    assign bsr_sel = (dec.kind == I_EXTEST) || (dec.kind == I_SAMPLE);

    always_comb begin
        dr_tdo = 1'b0;
        case (dec.kind)
            I_BYPASS:          dr_tdo = bypass_q;
            I_IDCODE:          dr_tdo = id_q[0];
            I_EXTEST, I_SAMPLE: dr_tdo = bsr_tdo;
            I_USER:            dr_tdo = |(ch_sr_lsb & user_sel);
            default:           dr_tdo = 1'b0;
        endcase
    end

    assign tdo_en = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign tdo    = (state == SHIFT_IR) ? ir_sr_q[0] :
                    (state == SHIFT_DR) ? dr_tdo     : 1'b0;

    assign bsr_tdi     = bsr_sel && tdi;
    assign bsr_shift   = bsr_sel && (state == SHIFT_DR);
    assign bsr_capture = bsr_sel && (state == CAPTURE_DR);
    assign bsr_update  = bsr_sel && (state == UPDATE_DR);
    assign bsr_mode    = (dec.kind == I_EXTEST);

endmodule

// File: doc/jtag_tap_core.md
JTAG_TAP_CORE -- requirements
Module: jtag_tap_core

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register length; legal range 2 to 8.
REQ-002 Parameter NUM_CH, default 2: number of user data-register channels; legal range 1 to 4.
REQ-003 Parameter CH_WIDTH, default 8: bit length of each user channel.
REQ-004 Parameter IDCODE, default 32'h1000_0001: device ID value; bit 0 SHALL be 1.
REQ-005 tck  in  1  sole clock; all state changes on the rising edge.
REQ-006 trst  in  1  reset, asynchronous, active-high.
REQ-007 tms  in  1  mode select.
REQ-008 tdi  in  1  serial data in.
REQ-009 tdo  out  1  serial data out.
REQ-010 tdo_en  out  1  high while in SHIFT_IR or SHIFT_DR.
REQ-011 tap_state  out  4  current FSM state encoding, from the shared package.
REQ-012 ir_value  out  IR_WIDTH  active instruction.
REQ-013 bsr_tdi, bsr_shift, bsr_capture, bsr_update, bsr_mode  out  1 each  boundary-scan chain controls.
REQ-014 bsr_tdo  in  1  boundary-scan chain serial return.
REQ-015 ch_cap_data  in  NUM_CH*CH_WIDTH  parallel capture data; channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
REQ-016 ch_cap_strobe  out  NUM_CH  one-cycle pulse on channel k's capture.
REQ-017 ch_upd_data  out  NUM_CH*CH_WIDTH  registered update values.
REQ-018 ch_upd_valid  out  NUM_CH  one-cycle pulse on channel k's update.

Function
REQ-019 The FSM SHALL implement the 16 IEEE 1149.1 states with the standard TMS transitions.
REQ-020 Five consecutive tck edges with tms=1 SHALL reach TEST_LOGIC_RESET from any state.
REQ-021 Decode: all-ones is BYPASS; 0 is EXTEST; 1 is IDCODE; 2 is SAMPLE_PRELOAD; 4+k for k<NUM_CH is USER channel k; every other code is BYPASS.
REQ-022 IR capture, on the edge in CAPTURE_IR: shift register loads {zeros, 2'b01}.
REQ-023 IR shift, on the edge in SHIFT_IR: shift right, tdi enters at the MSB.
REQ-024 IR update, on the edge in UPDATE_IR: ir_value takes the shift-register contents.
REQ-025 In TEST_LOGIC_RESET, ir_value SHALL be held at IDCODE (1).
REQ-026 The DR selected by ir_value captures on the CAPTURE_DR edge and shifts right on the SHIFT_DR edge.
REQ-027 Bypass DR: 1 bit; capture loads 0.
REQ-028 ID DR: 32 bits; capture loads IDCODE.
REQ-029 User channel k: CH_WIDTH bits; capture loads its slice of ch_cap_data.
REQ-030 ch_cap_strobe[k] SHALL be high for exactly the CAPTURE_DR cycle while USER k is active.
REQ-031 On the UPDATE_DR edge while USER k is active: ch_upd_data slice k loads the shift register, and ch_upd_valid[k] pulses high for the following cycle.
REQ-032 A channel that is not selected SHALL hold its ch_upd_data slice.
REQ-033 tdo is combinational: in SHIFT_IR it is the IR shift LSB; in SHIFT_DR it is the selected DR LSB (bsr_tdo for EXTEST or SAMPLE_PRELOAD); otherwise it is 0.
REQ-034 BSR controls are gated to EXTEST or SAMPLE_PRELOAD, and are otherwise low:
- bsr_tdi = tdi
- bsr_shift = SHIFT_DR
- bsr_capture = CAPTURE_DR
- bsr_update = UPDATE_DR
REQ-035 bsr_mode SHALL be 1 only while EXTEST is active.
REQ-036 Passing through UPDATE_DR without any shift SHALL re-apply the captured value unchanged.

Reset
REQ-037 trst high SHALL, asynchronously, set:
- state = TEST_LOGIC_RESET
- ir_value = 1
- all shift registers = 0
- ch_upd_data = 0
- strobes and valids = 0
REQ-038 All outputs SHALL be deterministic while trst is high:
- tdo = 0
- tdo_en = 0
- bsr_mode = 0
REQ-039 trst asserted in mid-shift SHALL discard partial data; no ch_upd_valid is generated.

Structure
REQ-040 A shared package jtag_pkg SHALL hold the tap_state_t enum, the fixed instruction code constants, and the USER_BASE=4 constant.
REQ-041 The FSM SHALL be a sub-module jtag_tap_fsm (tck, trst, tms -> state), reused by the core.
REQ-042 User channels SHALL be instantiated with a generate loop over NUM_CH.

Verification
REQ-043 Reset then IDCODE read: pulse trst, go to SHIFT_DR, shift 32 bits -> tdo yields 32'h1000_0001 LSB-first.
REQ-044 IR capture check: shift IR with tdi=1 for 4 bits -> tdo yields 1,0,0,0; after UPDATE_IR, ir_value=4'hF (BYPASS).
REQ-045 Bypass check: with BYPASS loaded, shift 8'hA5 through DR -> tdo is 0 followed by 8'hA5 delayed by one bit.
REQ-046 USER1 round trip: load IR=5 and ch_cap_data[15:8]=8'h3C, then shift in 8'h96 -> tdo returns 8'h3C, ch_upd_data[15:8]=8'h96, ch_upd_valid=2'b10 for one cycle, and ch_upd_data[7:0] is unchanged.
REQ-047 TMS-reset: from SHIFT_DR, hold tms=1 for 5 edges -> tap_state=TEST_LOGIC_RESET, ir_value=1, with no ch_upd_valid pulse.
REQ-048 EXTEST: load IR=0 -> bsr_mode=1; in SHIFT_DR, tdo follows bsr_tdo; an undefined code (e.g. 4'h9) behaves as BYPASS.
